tl_ab_buffer: RTL and testbench

Two-channel TileLink-UL buffer placed directly downstream of the 64-bit width-adapter stage, between it and the peripheral crossbar port. It decouples timing by registering the A channel (requests, adapter → slave) and the D channel (responses, slave → adapter) in independent circular FIFOs. Every output is driven from a flop. There is no combinational path from input valid to output valid, or from output ready to input ready. No field is modified.

---
 rtl/tl_ab_buffer.sv | 212 +++++++++++++++++++++
 tb/tb_tl_ab_buffer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ab_buffer.sv
// tl_ab_buffer: TileLink-UL A/D channel decoupling buffer.
// Two independent registered circular FIFOs; no field is modified.

module tl_ab_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enq_valid,
  output logic         enq_ready,
  input  logic [W-1:0] enq_bits,
  output logic         deq_valid,
  input  logic         deq_ready,
  output logic [W-1:0] deq_bits
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          enq;
  logic          deq;

  assign enq = enq_valid & enq_ready;
  assign deq = deq_valid & deq_ready;

  // Handshake flags decode registered count only, never the far side.
  assign enq_ready = (count != FULL);
  assign deq_valid = (count != '0);
  assign deq_bits  = mem[rptr];

  // Storage: accepted beat lands at the write pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enq) begin
      mem[wptr] <= enq_bits;
    end
  end

  // Write pointer; explicit wrap since depth need not be a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
    end else if (enq) begin
      wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
    end
  end

  // Read pointer; same explicit wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr <= '0;
    end else if (deq) begin
      rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
    end
  end

  // Occupancy: holds when both or neither side moves.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (enq && !deq) begin
      count <= count + 1'b1;
    end else if (deq && !enq) begin
      count <= count - 1'b1;
    end
  end

endmodule

module tl_ab_buffer #(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,

  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [2:0]  auto_in_a_bits_source,
  input  logic [30:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,

  input  logic        auto_out_a_ready,
  output logic        auto_out_a_valid,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [2:0]  auto_out_a_bits_size,
  output logic [2:0]  auto_out_a_bits_source,
  output logic [30:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,

  output logic        auto_out_d_ready,
  input  logic        auto_out_d_valid,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [1:0]  auto_out_d_bits_param,
  input  logic [2:0]  auto_out_d_bits_size,
  input  logic [2:0]  auto_out_d_bits_source,
  input  logic        auto_out_d_bits_sink,
  input  logic        auto_out_d_bits_denied,
  input  logic [63:0] auto_out_d_bits_data,
  input  logic        auto_out_d_bits_corrupt,

  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [2:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);

  localparam int A_W = 116;
  localparam int D_W = 78;

  logic [A_W-1:0] a_enq_bits;
  logic [A_W-1:0] a_deq_bits;
  logic [D_W-1:0] d_enq_bits;
  logic [D_W-1:0] d_deq_bits;

  assign a_enq_bits = {
    auto_in_a_bits_opcode,
    auto_in_a_bits_param,
    auto_in_a_bits_size,
    auto_in_a_bits_source,
    auto_in_a_bits_address,
    auto_in_a_bits_mask,
    auto_in_a_bits_data,
    auto_in_a_bits_corrupt
  };

  assign {
    auto_out_a_bits_opcode,
    auto_out_a_bits_param,
    auto_out_a_bits_size,
    auto_out_a_bits_source,
    auto_out_a_bits_address,
    auto_out_a_bits_mask,
    auto_out_a_bits_data,
    auto_out_a_bits_corrupt
  } = a_deq_bits;

  assign d_enq_bits = {
    auto_out_d_bits_opcode,
    auto_out_d_bits_param,
    auto_out_d_bits_size,
    auto_out_d_bits_source,
    auto_out_d_bits_sink,
    auto_out_d_bits_denied,
    auto_out_d_bits_data,
    auto_out_d_bits_corrupt
  };

  assign {
    auto_in_d_bits_opcode,
    auto_in_d_bits_param,
    auto_in_d_bits_size,
    auto_in_d_bits_source,
    auto_in_d_bits_sink,
    auto_in_d_bits_denied,
    auto_in_d_bits_data,
    auto_in_d_bits_corrupt
  } = d_deq_bits;

  tl_ab_fifo #(
    .DEPTH (A_DEPTH),
    .W     (A_W)
  ) u_a_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_in_a_valid),
    .enq_ready (auto_in_a_ready),
    .enq_bits  (a_enq_bits),
    .deq_valid (auto_out_a_valid),
    .deq_ready (auto_out_a_ready),
    .deq_bits  (a_deq_bits)
  );

  tl_ab_fifo #(
    .DEPTH (D_DEPTH),
    .W     (D_W)
  ) u_d_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_out_d_valid),
    .enq_ready (auto_out_d_ready),
    .enq_bits  (d_enq_bits),
    .deq_valid (auto_in_d_valid),
    .deq_ready (auto_in_d_ready),
    .deq_bits  (d_deq_bits)
  );

endmodule

// File: tb/tb_tl_ab_buffer.sv
// tb_tl_ab_buffer: directed scoreboard bench for tl_ab_buffer.
// Main DUT uses default depths; a second DUT uses A_DEPTH=3.

module tb_tl_ab_buffer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic         a_enq_valid;
  wire          a_enq_ready;
  logic [115:0] a_enq_bits;
  wire          a_deq_valid;
  logic         a_deq_ready;
  wire  [115:0] a_deq_bits;

  logic         d_enq_valid;
  wire          d_enq_ready;
  logic [77:0]  d_enq_bits;
  wire          d_deq_valid;
  logic         d_deq_ready;
  wire  [77:0]  d_deq_bits;

  logic         a3_enq_valid;
  wire          a3_enq_ready;
  logic [115:0] a3_enq_bits;
  wire          a3_deq_valid;
  logic         a3_deq_ready;
  wire  [115:0] a3_deq_bits;
  wire          d3_enq_ready;
  wire          d3_deq_valid;
  wire  [77:0]  d3_deq_bits;

  tl_ab_buffer u_dut (
    .clock                   (clock),
    .reset                   (reset),
    .auto_in_a_ready         (a_enq_ready),
    .auto_in_a_valid         (a_enq_valid),
    .auto_in_a_bits_opcode   (a_enq_bits[115:113]),
    .auto_in_a_bits_param    (a_enq_bits[112:110]),
    .auto_in_a_bits_size     (a_enq_bits[109:107]),
    .auto_in_a_bits_source   (a_enq_bits[106:104]),
    .auto_in_a_bits_address  (a_enq_bits[103:73]),
    .auto_in_a_bits_mask     (a_enq_bits[72:65]),
    .auto_in_a_bits_data     (a_enq_bits[64:1]),
    .auto_in_a_bits_corrupt  (a_enq_bits[0]),
    .auto_out_a_ready        (a_deq_ready),
    .auto_out_a_valid        (a_deq_valid),
    .auto_out_a_bits_opcode  (a_deq_bits[115:113]),
    .auto_out_a_bits_param   (a_deq_bits[112:110]),
    .auto_out_a_bits_size    (a_deq_bits[109:107]),
    .auto_out_a_bits_source  (a_deq_bits[106:104]),
    .auto_out_a_bits_address (a_deq_bits[103:73]),
    .auto_out_a_bits_mask    (a_deq_bits[72:65]),
    .auto_out_a_bits_data    (a_deq_bits[64:1]),
    .auto_out_a_bits_corrupt (a_deq_bits[0]),
    .auto_out_d_ready        (d_enq_ready),
    .auto_out_d_valid        (d_enq_valid),
    .auto_out_d_bits_opcode  (d_enq_bits[77:75]),
    .auto_out_d_bits_param   (d_enq_bits[74:73]),
    .auto_out_d_bits_size    (d_enq_bits[72:70]),
    .auto_out_d_bits_source  (d_enq_bits[69:67]),
    .auto_out_d_bits_sink    (d_enq_bits[66]),
    .auto_out_d_bits_denied  (d_enq_bits[65]),
    .auto_out_d_bits_data    (d_enq_bits[64:1]),
    .auto_out_d_bits_corrupt (d_enq_bits[0]),
    .auto_in_d_ready         (d_deq_ready),
    .auto_in_d_valid         (d_deq_valid),
    .auto_in_d_bits_opcode   (d_deq_bits[77:75]),
    .auto_in_d_bits_param    (d_deq_bits[74:73]),
    .auto_in_d_bits_size     (d_deq_bits[72:70]),
    .auto_in_d_bits_source   (d_deq_bits[69:67]),
    .auto_in_d_bits_sink     (d_deq_bits[66]),
    .auto_in_d_bits_denied   (d_deq_bits[65]),
    .auto_in_d_bits_data     (d_deq_bits[64:1]),
    .auto_in_d_bits_corrupt  (d_deq_bits[0])
  );

  tl_ab_buffer #(
    .A_DEPTH (3)
  ) u_dut3 (
    .clock                   (clock),
    .reset                   (reset),
    .auto_in_a_ready         (a3_enq_ready),
    .auto_in_a_valid         (a3_enq_valid),
    .auto_in_a_bits_opcode   (a3_enq_bits[115:113]),
    .auto_in_a_bits_param    (a3_enq_bits[112:110]),
    .auto_in_a_bits_size     (a3_enq_bits[109:107]),
    .auto_in_a_bits_source   (a3_enq_bits[106:104]),
    .auto_in_a_bits_address  (a3_enq_bits[103:73]),
    .auto_in_a_bits_mask     (a3_enq_bits[72:65]),
    .auto_in_a_bits_data     (a3_enq_bits[64:1]),
    .auto_in_a_bits_corrupt  (a3_enq_bits[0]),
    .auto_out_a_ready        (a3_deq_ready),
    .auto_out_a_valid        (a3_deq_valid),
    .auto_out_a_bits_opcode  (a3_deq_bits[115:113]),
    .auto_out_a_bits_param   (a3_deq_bits[112:110]),
    .auto_out_a_bits_size    (a3_deq_bits[109:107]),
    .auto_out_a_bits_source  (a3_deq_bits[106:104]),
    .auto_out_a_bits_address (a3_deq_bits[103:73]),
    .auto_out_a_bits_mask    (a3_deq_bits[72:65]),
    .auto_out_a_bits_data    (a3_deq_bits[64:1]),
    .auto_out_a_bits_corrupt (a3_deq_bits[0]),
    .auto_out_d_ready        (d3_enq_ready),
    .auto_out_d_valid        (1'b0),
    .auto_out_d_bits_opcode  (3'd0),
    .auto_out_d_bits_param   (2'd0),
    .auto_out_d_bits_size    (3'd0),
    .auto_out_d_bits_source  (3'd0),
    .auto_out_d_bits_sink    (1'b0),
    .auto_out_d_bits_denied  (1'b0),
    .auto_out_d_bits_data    (64'd0),
    .auto_out_d_bits_corrupt (1'b0),
    .auto_in_d_ready         (1'b1),
    .auto_in_d_valid         (d3_deq_valid),
    .auto_in_d_bits_opcode   (d3_deq_bits[77:75]),
    .auto_in_d_bits_param    (d3_deq_bits[74:73]),
    .auto_in_d_bits_size     (d3_deq_bits[72:70]),
    .auto_in_d_bits_source   (d3_deq_bits[69:67]),
    .auto_in_d_bits_sink     (d3_deq_bits[66]),
    .auto_in_d_bits_denied   (d3_deq_bits[65]),
    .auto_in_d_bits_data     (d3_deq_bits[64:1]),
    .auto_in_d_bits_corrupt  (d3_deq_bits[0])
  );

  int tests = 0;
  int fails = 0;

  logic [115:0] aq [$];
  logic [115:0] a3q [$];
  logic [77:0]  dq [$];

  logic a_acc;
  logic a3_acc;
  logic d_acc;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [115:0] mk_a(input logic [2:0]  op,
                                        input logic [2:0]  src,
                                        input logic [30:0] addr,
                                        input logic [7:0]  mask,
                                        input logic [63:0] data);
    return {op, 3'd0, 3'd3, src, addr, mask, data, 1'b0};
  endfunction

  function automatic logic [77:0] mk_d(input logic [2:0]  op,
                                       input logic [2:0]  src,
                                       input logic        denied,
                                       input logic [63:0] data);
    return {op, 2'd0, 3'd3, src, 1'b0, denied, data, 1'b0};
  endfunction

  // Called at a falling edge with inputs settled: checks flags
  // against the queue model, scores handshakes, crosses one edge.
  task automatic tick();
    logic [115:0] ea;
    logic [77:0]  ed;
    chk("a_valid", a_deq_valid, aq.size() != 0);
    chk("a_ready", a_enq_ready, aq.size() != 2);
    chk("d_valid", d_deq_valid, dq.size() != 0);
    chk("d_ready", d_enq_ready, dq.size() != 2);
    chk("a3_valid", a3_deq_valid, a3q.size() != 0);
    chk("a3_ready", a3_enq_ready, a3q.size() != 3);
    chk("d3_idle", {d3_deq_valid, d3_enq_ready}, 2'b01);
    a_acc  = a_enq_valid & a_enq_ready;
    d_acc  = d_enq_valid & d_enq_ready;
    a3_acc = a3_enq_valid & a3_enq_ready;
    if (a_deq_valid && a_deq_ready && aq.size() != 0) begin
      ea = aq.pop_front();
      chk("a_bits", a_deq_bits, ea);
    end
    if (d_deq_valid && d_deq_ready && dq.size() != 0) begin
      ed = dq.pop_front();
      chk("d_bits", d_deq_bits, ed);
    end
    if (a3_deq_valid && a3_deq_ready && a3q.size() != 0) begin
      ea = a3q.pop_front();
      chk("a3_bits", a3_deq_bits, ea);
    end
    if (a_acc)  aq.push_back(a_enq_bits);
    if (d_acc)  dq.push_back(d_enq_bits);
    if (a3_acc) a3q.push_back(a3_enq_bits);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    reset        = 1'b1;
    a_enq_valid  = 1'b0;
    a_enq_bits   = '0;
    a_deq_ready  = 1'b0;
    d_enq_valid  = 1'b0;
    d_enq_bits   = '0;
    d_deq_ready  = 1'b0;
    a3_enq_valid = 1'b0;
    a3_enq_bits  = '0;
    a3_deq_ready = 1'b0;

    // reset state
    @(negedge clock);
    chk("rst_a_ready", a_enq_ready, 1);
    chk("rst_a_valid", a_deq_valid, 0);
    chk("rst_d_ready", d_enq_ready, 1);
    chk("rst_d_valid", d_deq_valid, 0);
    chk("rst_a_bits", a_deq_bits, 0);
    chk("rst_d_bits", d_deq_bits, 0);
    chk("rst_a3_bits", a3_deq_bits, 0);
    chk("rst_d3_bits", d3_deq_bits, 0);
    reset = 1'b0;

    // single A beat, one-cycle latency
    a_deq_ready  = 1'b1;
    d_deq_ready  = 1'b1;
    a3_deq_ready = 1'b1;
    a_enq_valid  = 1'b1;
    a_enq_bits   = mk_a(3'd0, 3'd1, 31'h1000_0040, 8'hFF,
                        64'hDEAD_BEEF_CAFE_F00D);
    chk("t1_no_flow", a_deq_valid, 0);
    tick();
    chk("t1_acc", a_acc, 1);
    a_enq_valid = 1'b0;
    a_enq_bits  = '0;
    chk("t1_valid", a_deq_valid, 1);
    chk("t1_addr", a_deq_bits[103:73], 31'h1000_0040);
    chk("t1_data", a_deq_bits[64:1], 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    chk("t1_drop", a_deq_valid, 0);

    // backpressure: two accepted, third held until space
    a_deq_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_enq_valid = 1'b1;
      a_enq_bits  = mk_a(3'd0, i[2:0], 31'h2000 + 31'(i),
                         8'hF0, 64'h2222_0000 + 64'(i));
      tick();
      chk("t2_acc", a_acc, 1);
    end
    a_enq_bits = mk_a(3'd0, 3'd2, 31'h2002, 8'hF0, 64'h2222_0002);
    chk("t2_full", a_enq_ready, 0);
    tick();
    chk("t2_held", a_acc, 0);
    a_deq_ready = 1'b1;
    tick();
    chk("t2_held_deq", a_acc, 0);
    tick();
    chk("t2_acc3", a_acc, 1);
    a_enq_valid = 1'b0;
    tick();
    tick();
    chk("t2_empty", a_deq_valid, 0);

    // streaming 16 beats, no bubbles after the first
    for (int i = 0; i < 16; i++) begin
      a_enq_valid = 1'b1;
      a_enq_bits  = mk_a(3'd4, i[2:0], 31'h3000 + 31'(i * 8),
                         8'hFF, 64'h100 + 64'(i));
      if (i > 0) chk("t3_nobubble", a_deq_valid, 1);
      tick();
      chk("t3_acc", a_acc, 1);
    end
    a_enq_valid = 1'b0;
    tick();
    chk("t3_drain", a_deq_valid, 0);

    // wrap-around on the depth-3 instance, random readiness
    sent = 0;
    for (int c = 0; c < 400; c++) begin
      if (sent >= 20 && a3q.size() == 0) break;
      if (!a3_enq_valid && sent < 20) begin
        a3_enq_valid = ($urandom_range(0, 3) != 0);
        a3_enq_bits  = mk_a(3'd1, sent[2:0], 31'h4000 + 31'(sent),
                            8'h0F, {32'hA5A5_0000, 32'(sent)});
      end
      a3_deq_ready = 1'($urandom_range(0, 1));
      tick();
      if (a3_acc) begin
        sent++;
        a3_enq_valid = 1'b0;
      end
    end
    chk("t4_sent", sent, 20);
    chk("t4_drained", a3_deq_valid, 0);
    a3_deq_ready = 1'b1;

    // D stalled while A streams
    d_deq_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_enq_valid = 1'b1;
      a_enq_bits  = mk_a(3'd4, i[2:0], 31'h5000 + 31'(i),
                         8'h3C, 64'h5A5A_0000 + 64'(i));
      d_enq_valid = (i < 2);
      d_enq_bits  = (i == 0)
                  ? mk_d(3'd1, 3'd5, 1'b0, 64'h5555_0000_0000_5555)
                  : mk_d(3'd1, 3'd2, 1'b1, 64'h2222_0000_0000_2222);
      if (i > 0) chk("t5_a_stream", a_deq_valid, 1);
      tick();
      chk("t5_a_acc", a_acc, 1);
      if (i < 2) chk("t5_d_acc", d_acc, 1);
    end
    a_enq_valid = 1'b0;
    d_enq_valid = 1'b0;
    chk("t5_d_full", d_enq_ready, 0);
    chk("t5_d_hold", d_deq_valid, 1);
    chk("t5_d_head_src", d_deq_bits[69:67], 3'd5);
    d_enq_valid = 1'b1;
    d_enq_bits  = mk_d(3'd1, 3'd7, 1'b0, 64'h7777);
    tick();
    chk("t5_d_blocked", d_acc, 0);
    d_enq_valid = 1'b0;
    d_deq_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t5_d_empty", d_deq_valid, 0);

    // reset pulse with both FIFOs holding two beats
    a_deq_ready = 1'b0;
    d_deq_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_enq_valid = 1'b1;
      a_enq_bits  = mk_a(3'd0, i[2:0], 31'h6000 + 31'(i),
                         8'hFF, 64'hBAD0 + 64'(i));
      d_enq_valid = 1'b1;
      d_enq_bits  = mk_d(3'd0, i[2:0], 1'b0, 64'hBAD8 + 64'(i));
      tick();
    end
    a_enq_valid = 1'b0;
    d_enq_valid = 1'b0;
    chk("t6_a_full", a_enq_ready, 0);
    chk("t6_d_full", d_enq_ready, 0);
    reset = 1'b1;
    #1;
    chk("t6_a_valid", a_deq_valid, 0);
    chk("t6_d_valid", d_deq_valid, 0);
    chk("t6_a_ready", a_enq_ready, 1);
    chk("t6_d_ready", d_enq_ready, 1);
    chk("t6_a_bits", a_deq_bits, 0);
    chk("t6_d_bits", d_deq_bits, 0);
    #2;
    reset = 1'b0;
    aq.delete();
    dq.delete();
    @(negedge clock);
    a_deq_ready = 1'b1;
    d_deq_ready = 1'b1;
    repeat (3) tick();
    chk("t6_no_stale_a", a_deq_valid, 0);
    chk("t6_no_stale_d", d_deq_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
